// File: rtl/bsg_mux2_gatestack_sel_pipe_pkg.sv
// Shared types and constants for the gatestack select pipe.
package bsg_mux2_sel_pkg;

  localparam int mode_width_lp = 2;

  // Select source for tuples entering the pipe.
  typedef enum logic [mode_width_lp-1:0] {
    PASS   = 2'd0,
    STATIC = 2'd1,
    ROTATE = 2'd2,
    RSVD   = 2'd3
  } mode_e;

endpackage

// File: rtl/bsg_mux2_gatestack_sel_pipe_if.sv
// Tuple-in / tuple-out / config bundle for the gatestack select pipe.
interface bsg_mux2_gatestack_sel_pipe_if #(
  parameter int width_p = 3
) ();

  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data0_i;
  logic [width_p-1:0] data1_i;
  logic [width_p-1:0] sel_i;

  logic               cfg_we_i;
  logic [1:0]         cfg_mode_i;
  logic [width_p-1:0] cfg_sel_i;

  logic               v_o;
  logic               yumi_i;
  logic [width_p-1:0] data0_o;
  logic [width_p-1:0] data1_o;
  logic [width_p-1:0] sel_o;

  // Producer / consumer / config side (drives the pipe).
  modport master (
    output v_i, data0_i, data1_i, sel_i,
    output cfg_we_i, cfg_mode_i, cfg_sel_i,
    output yumi_i,
    input  ready_o, v_o, data0_o, data1_o, sel_o
  );

  // The pipe itself.
  modport slave (
    input  v_i, data0_i, data1_i, sel_i,
    input  cfg_we_i, cfg_mode_i, cfg_sel_i,
    input  yumi_i,
    output ready_o, v_o, data0_o, data1_o, sel_o
  );

endinterface

// File: rtl/bsg_mux2_gatestack_sel_pipe_two_fifo.sv
// Two-entry skid buffer holding {sel, data1, data0} tuples.
// ready_o and v_o depend only on registered count, so there is no
// combinational path from yumi_i to ready_o. Outputs read zero when empty.
module bsg_mux2_sel_two_fifo #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,

  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data0_i,
  input  logic [width_p-1:0] data1_i,
  input  logic [width_p-1:0] sel_i,

  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data0_o,
  output logic [width_p-1:0] data1_o,
  output logic [width_p-1:0] sel_o
);

  localparam int entry_width_lp = 3 * width_p;

  logic [entry_width_lp-1:0] mem_r [2];
  logic                      wptr_r;
  logic                      rptr_r;
  logic [1:0]                count_r;
  logic                      enq;
  logic                      deq;
  logic [entry_width_lp-1:0] head;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointers and occupancy; async reset drops v_o immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      unique case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written since the
  // output mux masks empty slots.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= {sel_i, data1_i, data0_i};
  end

  // Head selection, forced to zero when the buffer is empty.
  always_comb begin
    head = '0;
    if (v_o) head = mem_r[rptr_r];
  end

  assign data0_o = head[width_p-1:0];
  assign data1_o = head[2*width_p-1:width_p];
  assign sel_o   = head[3*width_p-1:2*width_p];

endmodule

// File: rtl/bsg_mux2_gatestack_sel_pipe.sv
// Registered upstream stage for the per-bit 2:1 gatestack mux.
// Holds the select configuration, computes the effective select at enqueue
// time and stores it with the tuple so later config changes never reach
// entries already buffered.
module bsg_mux2_gatestack_sel_pipe
  import bsg_mux2_sel_pkg::*;
#(
  parameter int width_p = 3
) (
  input logic                                   clk_i,
  input logic                                   reset_n_i,
  bsg_mux2_gatestack_sel_pipe_if.slave          bus
);

  mode_e              cfg_mode_r;
  logic [width_p-1:0] cfg_sel_r;
  logic [width_p-1:0] sel_eff;
  logic               enq;

  // Rotate left by one; for width_p=1 the shift terms collapse to identity.
  function automatic logic [width_p-1:0] rotl1(input logic [width_p-1:0] x);
    return (x << 1) | (x >> (width_p - 1));
  endfunction

  assign enq = bus.v_i & bus.ready_o;

  // Effective select uses the mode/pattern in force before this edge.
  always_comb begin
    sel_eff = bus.sel_i;
    unique case (cfg_mode_r)
      STATIC, ROTATE: sel_eff = cfg_sel_r;
      default:        sel_eff = bus.sel_i;
    endcase
  end

  // Config registers; an explicit write overrides the per-enqueue rotation.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cfg_mode_r <= PASS;
      cfg_sel_r  <= '0;
    end else if (bus.cfg_we_i) begin
      cfg_mode_r <= mode_e'(bus.cfg_mode_i);
      cfg_sel_r  <= bus.cfg_sel_i;
    end else if (enq && (cfg_mode_r == ROTATE)) begin
      cfg_sel_r  <= rotl1(cfg_sel_r);
    end
  end

  bsg_mux2_sel_two_fifo #(
    .width_p (width_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (bus.v_i),
    .ready_o   (bus.ready_o),
    .data0_i   (bus.data0_i),
    .data1_i   (bus.data1_i),
    .sel_i     (sel_eff),
    .v_o       (bus.v_o),
    .yumi_i    (bus.yumi_i),
    .data0_o   (bus.data0_o),
    .data1_o   (bus.data1_o),
    .sel_o     (bus.sel_o)
  );

endmodule

// File: tb/tb_bsg_mux2_gatestack_sel_pipe.sv
// Self-checking bench for bsg_mux2_gatestack_sel_pipe.
module tb_bsg_mux2_gatestack_sel_pipe;

  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] sel;
  } tup_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_mux2_gatestack_sel_pipe_if #(.width_p(W)) bus ();

  bsg_mux2_gatestack_sel_pipe #(.width_p(W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of tuples plus the config state.
  tup_t         q[$];
  int           m_mode;
  logic [W-1:0] m_sel;

  logic [W-1:0] sel_log[$];
  logic [W-1:0] d0_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rot_model(input logic [W-1:0] x);
    int v;
    v = int'(x);
    return W'((v * 2 + v / (1 << (W - 1))) % (1 << W));
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_sel  = '0;
  endtask

  task automatic check_all();
    tup_t h;
    h = '0;
    if (q.size() > 0) h = q[0];
    chk("v_o",     32'(bus.v_o),     32'(q.size() != 0));
    chk("ready_o", 32'(bus.ready_o), 32'(q.size() < 2));
    chk("data0_o", 32'(bus.data0_o), 32'(h.d0));
    chk("data1_o", 32'(bus.data1_o), 32'(h.d1));
    chk("sel_o",   32'(bus.sel_o),   32'(h.sel));
  endtask

  task automatic model_edge();
    bit           enq, deq;
    logic [W-1:0] eff;
    enq = bus.v_i && (q.size() < 2);
    deq = bus.yumi_i && (q.size() > 0);
    eff = (m_mode == 1 || m_mode == 2) ? m_sel : bus.sel_i;
    if (deq) void'(q.pop_front());
    if (enq) q.push_back('{d0: bus.data0_i, d1: bus.data1_i, sel: eff});
    if (bus.cfg_we_i) begin
      m_mode = int'(bus.cfg_mode_i);
      m_sel  = bus.cfg_sel_i;
    end else if (enq && m_mode == 2) begin
      m_sel = rot_model(m_sel);
    end
  endtask

  // Check mid-cycle, take the edge, advance the model, drive after the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    if (bus.yumi_i) begin
      chk("yumi_protocol", 32'(bus.v_o), 32'd1);
      if (bus.v_o) begin
        sel_log.push_back(bus.sel_o);
        d0_log.push_back(bus.data0_o);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_tuple(input logic v, input logic [W-1:0] d0,
                             input logic [W-1:0] d1, input logic [W-1:0] s);
    bus.v_i     = v;
    bus.data0_i = d0;
    bus.data1_i = d1;
    bus.sel_i   = s;
  endtask

  task automatic drive_cfg(input logic we, input logic [1:0] mode, input logic [W-1:0] s);
    bus.cfg_we_i   = we;
    bus.cfg_mode_i = mode;
    bus.cfg_sel_i  = s;
  endtask

  initial begin
    drive_tuple(1'b0, '0, '0, '0);
    drive_cfg(1'b0, 2'd0, '0);
    bus.yumi_i = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single PASS tuple, one-cycle latency, downstream mux result
    drive_tuple(1'b1, 3'b001, 3'b110, 3'b101);
    cycle();
    drive_tuple(1'b0, '0, '0, '0);
    chk("latency_v", 32'(bus.v_o), 32'd1);
    chk("mux_out", 32'((bus.data0_o & ~bus.sel_o) | (bus.data1_o & bus.sel_o)), 32'(3'b100));
    cycle();
    bus.yumi_i = 1'b1;
    cycle();
    bus.yumi_i = 1'b0;
    cycle();

    // Fill: third tuple is refused while full
    d0_log.delete();
    drive_tuple(1'b1, 3'b010, 3'b101, 3'b011);
    cycle();
    drive_tuple(1'b1, 3'b100, 3'b011, 3'b110);
    cycle();
    drive_tuple(1'b1, 3'b111, 3'b000, 3'b001);
    cycle();
    chk("full_ready", 32'(bus.ready_o), 32'd0);
    chk("full_head",  32'(bus.data0_o), 32'(3'b010));

    // Drain while the third tuple keeps being offered
    bus.yumi_i = 1'b1;
    cycle();
    cycle();
    drive_tuple(1'b0, '0, '0, '0);
    cycle();
    bus.yumi_i = 1'b0;
    cycle();
    chk("order_count", 32'(d0_log.size()), 32'd3);
    if (d0_log.size() == 3) begin
      chk("order_0", 32'(d0_log[0]), 32'(3'b010));
      chk("order_1", 32'(d0_log[1]), 32'(3'b100));
      chk("order_2", 32'(d0_log[2]), 32'(3'b111));
    end

    // ROTATE with a config write coincident with the third enqueue
    sel_log.delete();
    drive_cfg(1'b1, 2'd2, 3'b001);
    cycle();
    drive_cfg(1'b0, 2'd0, '0);
    for (int i = 0; i < 4; i++) begin
      drive_tuple(1'b1, W'($urandom), W'($urandom), W'($urandom));
      if (i == 2) drive_cfg(1'b1, 2'd2, 3'b011);
      else        drive_cfg(1'b0, 2'd0, '0);
      bus.yumi_i = (q.size() > 0);
      cycle();
    end
    drive_tuple(1'b0, '0, '0, '0);
    drive_cfg(1'b0, 2'd0, '0);
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      bus.yumi_i = 1'b1;
      cycle();
    end
    bus.yumi_i = 1'b0;
    chk("rot_count", 32'(sel_log.size()), 32'd4);
    if (sel_log.size() == 4) begin
      chk("rot_0", 32'(sel_log[0]), 32'(3'b001));
      chk("rot_1", 32'(sel_log[1]), 32'(3'b010));
      chk("rot_2", 32'(sel_log[2]), 32'(3'b100));
      chk("rot_3", 32'(sel_log[3]), 32'(3'b011));
    end

    // STATIC: buffered selects survive a switch back to PASS
    drive_cfg(1'b1, 2'd1, 3'b111);
    cycle();
    drive_cfg(1'b0, 2'd0, '0);
    drive_tuple(1'b1, 3'b101, 3'b010, 3'b000);
    cycle();
    drive_tuple(1'b1, 3'b011, 3'b100, 3'b000);
    cycle();
    drive_tuple(1'b0, '0, '0, '0);
    drive_cfg(1'b1, 2'd0, 3'b000);
    cycle();
    drive_cfg(1'b0, 2'd0, '0);
    chk("static_sel_0", 32'(bus.sel_o), 32'(3'b111));
    bus.yumi_i = 1'b1;
    cycle();
    chk("static_sel_1", 32'(bus.sel_o), 32'(3'b111));
    cycle();
    bus.yumi_i = 1'b0;

    // Async reset mid-cycle with two entries buffered and mode ROTATE
    drive_tuple(1'b1, 3'b110, 3'b001, 3'b010);
    drive_cfg(1'b1, 2'd2, 3'b101);
    cycle();
    drive_cfg(1'b0, 2'd0, '0);
    drive_tuple(1'b1, 3'b001, 3'b111, 3'b100);
    cycle();
    drive_tuple(1'b0, '0, '0, '0);
    chk("pre_reset_full", 32'(bus.ready_o), 32'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_v_o",     32'(bus.v_o),     32'd0);
    chk("rst_ready_o", 32'(bus.ready_o), 32'd1);
    chk("rst_data0_o", 32'(bus.data0_o), 32'd0);
    chk("rst_data1_o", 32'(bus.data1_o), 32'd0);
    chk("rst_sel_o",   32'(bus.sel_o),   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_tuple(1'b1, 3'b010, 3'b101, 3'b110);
    cycle();
    drive_tuple(1'b0, '0, '0, '0);
    chk("rst_mode_pass", 32'(bus.sel_o), 32'(3'b110));
    bus.yumi_i = 1'b1;
    cycle();
    bus.yumi_i = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_tuple(1'($urandom), W'($urandom), W'($urandom), W'($urandom));
      drive_cfg(($urandom_range(0, 7) == 0), 2'($urandom), W'($urandom));
      bus.yumi_i = (q.size() > 0) && 1'($urandom);
      cycle();
    end
    drive_tuple(1'b0, '0, '0, '0);
    drive_cfg(1'b0, 2'd0, '0);
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      bus.yumi_i = 1'b1;
      cycle();
    end
    bus.yumi_i = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
